instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction and address width.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 64: program memory word count; the fetch address wraps modulo this value.
REQ-003 SHALL have parameter RESET_PC, default 0: word address fetched first after reset.
REQ-004 SHALL have ports, clock and reset first:
- Clk_i  input  1  sole clock, rising edge.
- Reset_n_i  input  1  asynchronous, active-low reset.
- Enable_o  output  1  program memory read enable.
- Address_o  output  DATA_WIDTH  program memory word address.
- Instruction_i  input  DATA_WIDTH  program memory data, combinational from Address_o/Enable_o.
- Redirect_i  input  1  branch/jump request; flushes and reloads PC.
- Target_i  input  DATA_WIDTH  redirect word address.
- Valid_o  output  1  Instr_o holds a valid instruction.
- Ready_i  input  1  decode accepts Instr_o this cycle.
- Instr_o  output  DATA_WIDTH  oldest buffered instruction.
- Pc_o  output  DATA_WIDTH  word address of Instr_o (present only with the REQ-024 macro).

Function
REQ-005 SHALL hold a PC register and a 2-entry prefetch FIFO (instruction, plus PC tag when configured).
REQ-006 SHALL implement states IDLE, RUN and FULL.
- IDLE: entered on reset; moves to RUN on the first clock edge after reset release; no fetch.
- RUN: FIFO has space.
- FULL: FIFO holds 2 entries and no pop occurs this cycle.
REQ-007 SHALL drive Address_o from the PC register at all times.
REQ-008 SHALL assert Enable_o combinationally when the state is not IDLE, Redirect_i=0, and (FIFO count<2 or a pop occurs this cycle).
REQ-009 SHALL treat a cycle with Enable_o=1 as a fetch: at the clock edge, push Instruction_i (and PC) into the FIFO and set PC to (PC+1) mod MEMORY_DEPTH.
REQ-010 SHALL treat a cycle with Valid_o=1 and Ready_i=1 as a pop; Instr_o advances at that edge.
REQ-011 SHALL set Valid_o=1 exactly when the FIFO count>0; Instr_o SHALL be the FIFO head, registered with no combinational path from Instruction_i.
REQ-012 SHALL have a latency of 1 cycle from fetch to Valid_o: a fetch in cycle t presents the instruction in cycle t+1 if the FIFO was empty.
REQ-013 SHALL sustain 1 instruction per cycle while Ready_i=1 continuously.
REQ-014 SHALL keep the FIFO count unchanged when a push and a pop coincide, including when the FIFO is full.
REQ-015 SHALL keep Instr_o and Pc_o stable while Valid_o=1 and Ready_i=0.
REQ-016 SHALL handle Redirect_i=1 as follows:
- at the edge, empty the FIFO, discard any pop, and load PC with Target_i mod MEMORY_DEPTH;
- Valid_o=0 in the next cycle;
- the Target_i instruction becomes valid 2 cycles after the redirect cycle.
REQ-017 SHALL give Redirect_i priority over fetch, pop and state; the state after a redirect is RUN, or IDLE if the redirect arrives in IDLE.
REQ-018 SHALL wrap the PC at MEMORY_DEPTH-1 to 0 with no gap in fetching.
REQ-019 SHALL compute the PC arithmetic in DATA_WIDTH bits, then reduce it modulo MEMORY_DEPTH; MEMORY_DEPTH need not be a power of two.

Reset
REQ-020 SHALL, on Reset_n_i=0, asynchronously set: PC=RESET_PC, FIFO count=0, state=IDLE, Valid_o=0, Enable_o=0, Instr_o=0, Pc_o=0.
REQ-021 SHALL discard all in-flight fetches and FIFO contents when reset is asserted mid-operation.
REQ-022 SHALL release reset synchronously to Clk_i internally; the first fetch of RESET_PC occurs in the second cycle after release.
REQ-023 SHALL ignore Redirect_i and Ready_i while reset is asserted.

Configuration
REQ-024 SHALL use macro FETCH_PC_TAG_EN.
- When defined: the FIFO stores the PC per entry and Pc_o presents the word address of Instr_o; Pc_o follows the same reset and stability rules as Instr_o.
- When undefined: the Pc_o port and the tag storage are absent; all other behaviour is identical.

Verification
REQ-025 Reset, program memory word k = 0x1000_0000+k, Ready_i=1 -> Valid_o first rises 2 cycles after release with 0x1000_0000, then 0x1000_0001, 0x1000_0002 on consecutive cycles.
REQ-026 Ready_i=0 for 5 cycles -> Enable_o drops after 2 pushes, Instr_o holds 0x1000_0000; on Ready_i=1, the sequence continues with no loss or duplicate.
REQ-027 Redirect_i=1 with Target_i=0x20 while the FIFO is full -> Valid_o=0 next cycle, then Instr_o=0x1000_0020 (Pc_o=0x20); the flushed entries are never presented.
REQ-028 Target_i=62 with MEMORY_DEPTH=64 -> addresses 62, 63, 0, 1; the instructions for words 62, 63, 0, 1 are presented in order.
REQ-029 Reset asserted while Valid_o=1 with the FIFO full -> all outputs zero immediately; after release, fetching restarts at RESET_PC.
REQ-030 Random Ready_i over 1000 cycles with FETCH_PC_TAG_EN defined -> Pc_o always equals the previously accepted Pc_o+1 mod 64.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Program-counter driven instruction fetch unit. It has a 2-entry
//            registered prefetch FIFO, a redirect (branch/jump) flush, and a PC
//            that wraps modulo MEMORY_DEPTH.
//            Optional macro FETCH_PC_TAG_EN adds a per-entry PC tag and Pc_o.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 64,
    parameter int RESET_PC     = 0
) (
    input  logic                  Clk_i,
    input  logic                  Reset_n_i,
    output logic                  Enable_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Instr_o
`ifdef FETCH_PC_TAG_EN
    ,
    output logic [DATA_WIDTH-1:0] Pc_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] DEPTH_W    = DATA_WIDTH'(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] RESET_PC_W = DATA_WIDTH'(RESET_PC % MEMORY_DEPTH);

`ifdef FETCH_PC_TAG_EN
    // Each FIFO entry is {pc, instruction}.
    localparam int ENTRY_W = 2 * DATA_WIDTH;
`else
    // Each FIFO entry is the instruction only.
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]           count_q, count_d;
    logic [ENTRY_W-1:0]   head_q, head_d;   // oldest entry, drives the outputs
    logic [ENTRY_W-1:0]   tail_q, tail_d;   // second entry

    logic                  w_pop;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_target_mod;
    logic [ENTRY_W-1:0]    w_entry;

`ifdef FETCH_PC_TAG_EN
    assign w_entry = {pc_q, Instruction_i};
    assign Pc_o    = head_q[ENTRY_W-1 -: DATA_WIDTH];
`else
    assign w_entry = Instruction_i;
`endif

    assign Address_o = pc_q;
    assign Valid_o   = (count_q != 2'd0);
    assign Instr_o   = head_q[DATA_WIDTH-1:0];

    // The PC always stays below MEMORY_DEPTH, so comparing pc+1 against the depth
    // is a complete modulo reduction for the increment. Targets can be
    // arbitrary, so they go through a full modulo.
    assign w_pc_inc     = pc_q + DATA_WIDTH'(1);
    assign w_pc_next    = (w_pc_inc >= DEPTH_W) ? '0 : w_pc_inc;
    assign w_target_mod = Target_i % DEPTH_W;

    // Handshake decode: pop on valid&ready; fetch when running, not redirecting,
    // and there is room (or room is being made by a pop this cycle).
    always_comb begin
        w_pop    = (count_q != 2'd0) && Ready_i;
        Enable_o = (state_q != ST_IDLE) && !Redirect_i && ((count_q != 2'd2) || w_pop);
        w_push   = Enable_o;
    end

    // Next-state computation for PC, FIFO and state; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (Redirect_i) begin
            count_d = 2'd0;
            pc_d    = w_target_mod;
            state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_RUN;
        end else begin
            if (w_push) begin
                pc_d = w_pc_next;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = w_entry;
                    end else begin
                        tail_d = w_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop keep the occupancy unchanged.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = w_entry;
                    end else begin
                        head_d = w_entry;
                    end
                end
                default: begin
                end
            endcase
            if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
            end else begin
                state_d = (count_d == 2'd2) ? ST_FULL : ST_RUN;
            end
        end
    end

    // State, PC and FIFO registers with asynchronous active-low reset.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_W;
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch. It uses directed
//            scenarios followed by random Ready_i/Redirect_i traffic. The
//            reference model is a queue of word addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          Reset_n_i;
    logic          Enable_o;
    logic [DW-1:0] Address_o;
    logic [DW-1:0] Instruction_i;
    logic          Redirect_i;
    logic [DW-1:0] Target_i;
    logic          Valid_o;
    logic          Ready_i;
    logic [DW-1:0] Instr_o;
`ifdef FETCH_PC_TAG_EN
    logic [DW-1:0] Pc_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the word addresses held in the prefetch buffer, the
    // model PC, and whether the unit has left its post-reset idle cycle.
    int unsigned q[$];
    int unsigned pc_m;
    bit          started;

    always #5 clk = ~clk;

    // Program memory: word k holds 0x1000_0000 + k.
    assign Instruction_i = Enable_o ? (32'h1000_0000 + Address_o) : 32'hDEAD_BEEF;

    instruction_fetch #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(DEPTH),
        .RESET_PC    (0)
    ) dut (
        .Clk_i        (clk),
        .Reset_n_i    (Reset_n_i),
        .Enable_o     (Enable_o),
        .Address_o    (Address_o),
        .Instruction_i(Instruction_i),
        .Redirect_i   (Redirect_i),
        .Target_i     (Target_i),
        .Valid_o      (Valid_o),
        .Ready_i      (Ready_i),
        .Instr_o      (Instr_o)
`ifdef FETCH_PC_TAG_EN
        ,
        .Pc_o         (Pc_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. It starts and ends at a falling edge: drive the inputs,
    // check against the model, then advance the model past the rising edge.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit exp_valid;
        bit exp_pop;
        bit exp_en;
        Ready_i    = rdy;
        Redirect_i = redir;
        Target_i   = tgt;
        #1;
        exp_valid = (q.size() > 0);
        exp_pop   = exp_valid && rdy;
        exp_en    = started && !redir && ((q.size() < 2) || exp_pop);
        check("valid",   32'(Valid_o),  32'(exp_valid));
        check("enable",  32'(Enable_o), 32'(exp_en));
        check("address", Address_o,     pc_m);
        if (exp_valid) begin
            check("instr", Instr_o, 32'h1000_0000 + q[0]);
`ifdef FETCH_PC_TAG_EN
            check("pc", Pc_o, q[0]);
`endif
        end
        if (redir) begin
            q.delete();
            pc_m = tgt % DEPTH;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_en) begin
                q.push_back(pc_m);
                pc_m = (pc_m + 1) % DEPTH;
            end
            started = 1'b1;
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle and check that the outputs clear at once. Redirect
    // and Ready are held active during reset and must be ignored. Release on a
    // falling edge.
    task automatic do_reset();
        #2;
        Reset_n_i  = 1'b0;
        Ready_i    = 1'b1;
        Redirect_i = 1'b1;
        Target_i   = 32'h15;
        #1;
        check("rst_valid",   32'(Valid_o),  32'd0);
        check("rst_enable",  32'(Enable_o), 32'd0);
        check("rst_instr",   Instr_o,       32'd0);
        check("rst_address", Address_o,     32'd0);
`ifdef FETCH_PC_TAG_EN
        check("rst_pc", Pc_o, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        Redirect_i = 1'b0;
        Reset_n_i  = 1'b1;
        q.delete();
        pc_m    = 0;
        started = 1'b0;
    endtask

    initial begin
        Reset_n_i  = 1'b0;
        Ready_i    = 1'b0;
        Redirect_i = 1'b0;
        Target_i   = '0;
        @(negedge clk);

        // Reset, then streaming at full rate.
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Backpressure from reset, then resume.
        do_reset();
        repeat (7) cycle(1'b0, 1'b0, 32'd0);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Redirect to 0x20 while the buffer is full.
        repeat (3) cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h20);
        repeat (2) cycle(1'b0, 1'b0, 32'd0);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        // Wrap from word 62 through 63 to 0.
        cycle(1'b1, 1'b1, 32'd62);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Large target reduced modulo depth (0xFFFFFF7E mod 64 = 62).
        cycle(1'b1, 1'b1, 32'hFFFF_FF7E);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        // Reset while the buffer is full, then restart at RESET_PC.
        repeat (3) cycle(1'b0, 1'b0, 32'd0);
        do_reset();
        repeat (5) cycle(1'b1, 1'b0, 32'd0);

        // Redirect arriving in the idle cycle right after release.
        do_reset();
        cycle(1'b1, 1'b1, 32'd5);
        repeat (5) cycle(1'b1, 1'b0, 32'd0);

        // Random traffic.
        repeat (1000) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
